// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine controller.
// Coin values, FSM states and the price sanity check live here.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE
    } state_t;

    localparam int unsigned NICKEL    = 5;
    localparam int unsigned DIME      = 10;
    localparam int unsigned QUARTER   = 25;
    localparam int unsigned PRICE_MAX = 215;

    // Largest overshoot: PRICE-5 of credit plus all three coins at once.
    localparam int unsigned OVERSHOOT = NICKEL + DIME + QUARTER - NICKEL;

    function automatic bit price_ok(int unsigned price);
        return (price % NICKEL == 0) && (price >= NICKEL)
            && (price <= PRICE_MAX);
    endfunction

    function automatic bit width_ok(int unsigned price, int unsigned w);
        return (price + OVERSHOOT) < (64'd1 << w);
    endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change-coin selector: largest coin that fits the credit.
// sel_o is one-hot {quarter, dime, nickel}; dec_o is that coin's value.
import vend_pkg::*;

module vend_change_sel #(
    parameter int unsigned CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit_i,
    output logic [2:0]          sel_o,
    output logic [CREDIT_W-1:0] dec_o
);

    // Pick the largest coin not exceeding the remaining credit.
    always_comb begin
        sel_o = 3'b000;
        dec_o = '0;
        if (credit_i >= CREDIT_W'(QUARTER)) begin
            sel_o = 3'b100;
            dec_o = CREDIT_W'(QUARTER);
        end else if (credit_i >= CREDIT_W'(DIME)) begin
            sel_o = 3'b010;
            dec_o = CREDIT_W'(DIME);
        end else begin
            sel_o = 3'b001;
            dec_o = CREDIT_W'(NICKEL);
        end
    end

endmodule

// File: rtl/vend_fsm.sv
// Vending transaction controller: accumulates credit, vends, then
// returns change one coin per cycle. All outputs are registered-decoded.
import vend_pkg::*;

module vend_fsm #(
    parameter int unsigned PRICE    = 65,
    parameter int unsigned CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nickel_p,
    input  logic                dime_p,
    input  logic                quarter_p,
    input  logic                cancel_p,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                dispense,
    output logic                quarter_out,
    output logic                dime_out,
    output logic                nickel_out,
    output logic                coin_reject
);

    if (!price_ok(PRICE)) begin : g_bad_price
        $error("vend_fsm: PRICE must be a multiple of 5 in 5..215");
    end
    if (!width_ok(PRICE, CREDIT_W)) begin : g_bad_width
        $error("vend_fsm: CREDIT_W too narrow for PRICE+35");
    end

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;

    logic [CREDIT_W-1:0] coin_sum;
    logic [CREDIT_W-1:0] credit_nxt;
    logic                coin_any;
    logic [2:0]          chg_sel;
    logic [CREDIT_W-1:0] chg_dec;

    vend_change_sel #(
        .CREDIT_W (CREDIT_W)
    ) u_change_sel (
        .credit_i (credit_q),
        .sel_o    (chg_sel),
        .dec_o    (chg_dec)
    );

    // Value of all coins pulsed this cycle; simultaneous pulses add up.
    always_comb begin
        coin_sum = '0;
        if (nickel_p)  coin_sum = coin_sum + CREDIT_W'(NICKEL);
        if (dime_p)    coin_sum = coin_sum + CREDIT_W'(DIME);
        if (quarter_p) coin_sum = coin_sum + CREDIT_W'(QUARTER);
        credit_nxt = credit_q + coin_sum;
        coin_any   = nickel_p | dime_p | quarter_p;
    end

    // Next-state and next-credit logic; cancel wins over vending.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        unique case (state_q)
            IDLE, COLLECT: begin
                credit_d = credit_nxt;
                if (cancel_p) begin
                    state_d = (credit_nxt != '0) ? CHANGE : IDLE;
                end else if (credit_nxt >= CREDIT_W'(PRICE)) begin
                    state_d = VEND;
                end else if (credit_nxt != '0) begin
                    state_d = COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            VEND: begin
                credit_d = credit_q - CREDIT_W'(PRICE);
                state_d  = (credit_d != '0) ? CHANGE : IDLE;
                reject_d = coin_any;
            end
            CHANGE: begin
                credit_d = credit_q - chg_dec;
                state_d  = (credit_d != '0) ? CHANGE : IDLE;
                reject_d = coin_any;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // State, credit and reject registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    // Output decode from registered state and credit only.
    always_comb begin
        credit      = credit_q;
        busy        = (state_q == VEND) || (state_q == CHANGE);
        dispense    = (state_q == VEND);
        quarter_out = (state_q == CHANGE) && chg_sel[2];
        dime_out    = (state_q == CHANGE) && chg_sel[1];
        nickel_out  = (state_q == CHANGE) && chg_sel[0];
        coin_reject = reject_q;
    end

endmodule

// File: tb/tb_vend_fsm.sv
// Testbench for vend_fsm: directed test-plan steps followed by random
// coin traffic, all checked against a transaction-level model.
module tb_vend_fsm;

    localparam int PRICE    = 65;
    localparam int CREDIT_W = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                nickel_p = 1'b0;
    logic                dime_p = 1'b0;
    logic                quarter_p = 1'b0;
    logic                cancel_p = 1'b0;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                dispense;
    logic                quarter_out;
    logic                dime_out;
    logic                nickel_out;
    logic                coin_reject;

    int total = 0;
    int bad   = 0;

    vend_fsm #(
        .PRICE    (PRICE),
        .CREDIT_W (CREDIT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .nickel_p    (nickel_p),
        .dime_p      (dime_p),
        .quarter_p   (quarter_p),
        .cancel_p    (cancel_p),
        .credit      (credit),
        .busy        (busy),
        .dispense    (dispense),
        .quarter_out (quarter_out),
        .dime_out    (dime_out),
        .nickel_out  (nickel_out),
        .coin_reject (coin_reject)
    );

    always #5 clk = ~clk;

    // One expected output cycle of the machine.
    typedef struct {
        int credit;
        bit busy;
        bit disp;
        bit qo;
        bit dout;
        bit no;
    } ent_t;

    ent_t cur;
    ent_t sched[$];
    bit   m_rej;

    function automatic ent_t mk(int c, bit b, bit ds, bit q, bit d, bit n);
        ent_t e;
        e.credit = c;
        e.busy   = b;
        e.disp   = ds;
        e.qo     = q;
        e.dout   = d;
        e.no     = n;
        return e;
    endfunction

    // Refund list: largest coin first until nothing is owed.
    task automatic push_change(input int amount);
        int c = amount;
        while (c > 0) begin
            if (c >= 25) begin
                sched.push_back(mk(c, 1, 0, 1, 0, 0));
                c -= 25;
            end else if (c >= 10) begin
                sched.push_back(mk(c, 1, 0, 0, 1, 0));
                c -= 10;
            end else begin
                sched.push_back(mk(c, 1, 0, 0, 0, 1));
                c -= 5;
            end
        end
    endtask

    task automatic model_edge(input bit n, input bit d, input bit q,
                              input bit c, input bit r);
        int t;
        if (r) begin
            sched.delete();
            cur   = mk(0, 0, 0, 0, 0, 0);
            m_rej = 0;
        end else if (cur.busy) begin
            m_rej = n | d | q;
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = mk(0, 0, 0, 0, 0, 0);
        end else begin
            m_rej = 0;
            t = cur.credit + 5 * n + 10 * d + 25 * q;
            if (c) begin
                if (t > 0) begin
                    push_change(t);
                    cur = sched.pop_front();
                end else begin
                    cur = mk(0, 0, 0, 0, 0, 0);
                end
            end else if (t >= PRICE) begin
                sched.push_back(mk(t, 1, 1, 0, 0, 0));
                push_change(t - PRICE);
                cur = sched.pop_front();
            end else begin
                cur = mk(t, 0, 0, 0, 0, 0);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("credit", 32'(credit), cur.credit);
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("dispense", 32'(dispense), 32'(cur.disp));
        chk("coins", 32'({quarter_out, dime_out, nickel_out}),
            32'({cur.qo, cur.dout, cur.no}));
        chk("reject", 32'(coin_reject), 32'(m_rej));
    endtask

    // Drive one cycle of inputs, advance one edge, check against model.
    task automatic cyc(input bit n, input bit d, input bit q,
                       input bit c, input bit r);
        nickel_p  = n;
        dime_p    = d;
        quarter_p = q;
        cancel_p  = c;
        reset     = r;
        @(posedge clk);
        model_edge(n, d, q, c, r);
        #1;
        check_model();
    endtask

    initial begin
        cur   = mk(0, 0, 0, 0, 0, 0);
        m_rej = 0;

        // Reset for two cycles.
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rst_credit", 32'(credit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pulses", 32'({dispense, quarter_out, dime_out,
            nickel_out, coin_reject}), 0);
        cyc(0, 0, 0, 0, 0);

        // Exact price: Q, Q, D, N.
        cyc(0, 0, 1, 0, 0);
        chk("qqdn_c1", 32'(credit), 25);
        cyc(0, 0, 1, 0, 0);
        chk("qqdn_c2", 32'(credit), 50);
        cyc(0, 1, 0, 0, 0);
        chk("qqdn_c3", 32'(credit), 60);
        cyc(1, 0, 0, 0, 0);
        chk("qqdn_disp", 32'(dispense), 1);
        chk("qqdn_credit", 32'(credit), 65);
        cyc(0, 0, 0, 0, 0);
        chk("qqdn_idle", 32'({busy, credit}), 0);

        // Three quarters: vend then one dime of change.
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("qqq_disp", 32'(dispense), 1);
        cyc(0, 0, 0, 0, 0);
        chk("qqq_dime", 32'({quarter_out, dime_out, nickel_out}), 2);
        cyc(0, 0, 0, 0, 0);
        chk("qqq_idle", 32'({busy, credit}), 0);

        // Simultaneous quarter and dime, then cancel the 35 cents.
        cyc(0, 1, 1, 0, 0);
        chk("qd_credit", 32'(credit), 35);
        chk("qd_busy", 32'(busy), 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Quarter then cancel: single quarter refunded.
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("cancel_q", 32'(quarter_out), 1);
        chk("cancel_nodisp", 32'(dispense), 0);
        cyc(0, 0, 0, 0, 0);
        chk("cancel_idle", 32'(credit), 0);

        // Dime pulse during change is rejected one cycle later.
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        chk("rej_pulse", 32'(coin_reject), 1);
        chk("rej_credit", 32'(credit), 35);
        cyc(0, 0, 0, 0, 0);
        chk("rej_clear", 32'(coin_reject), 0);
        cyc(0, 0, 0, 0, 0);

        // 85 cents, reset on the first change cycle.
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("r85_vend", 32'(credit), 85);
        cyc(0, 0, 0, 0, 0);
        chk("r85_chg", 32'(credit), 20);
        cyc(0, 0, 0, 0, 1);
        chk("r85_credit", 32'(credit), 0);
        chk("r85_coins", 32'({quarter_out, dime_out, nickel_out}), 0);
        cyc(0, 0, 0, 0, 0);

        // Random coin traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 127) == 0);
        end
        cyc(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_fsm.md
# vend_fsm

Vending-machine transaction controller, directly downstream of the button debouncers. Consumes the single-cycle press pulses for coin and cancel buttons, accumulates credit, and vends once credit reaches the price. It then returns change one coin per cycle using greedy quarter/dime/nickel selection. Its outputs drive the dispense actuator, coin-return solenoids and the credit display.

## Interface
- PRICE, 65: item price in cents; multiple of 5, range 5..215.
- CREDIT_W, 8: credit register width; must hold PRICE+35.

- clk  in  1  system clock, shared with debouncers.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- nickel_p  in  1  one-cycle pulse: 5¢ inserted.
- dime_p  in  1  one-cycle pulse: 10¢ inserted.
- quarter_p  in  1  one-cycle pulse: 25¢ inserted.
- cancel_p  in  1  one-cycle pulse: abort transaction, refund credit.
- credit  out  CREDIT_W  current credit in cents.
- busy  out  1  high in VEND and CHANGE.
- dispense  out  1  one-cycle pulse: release item.
- quarter_out, dime_out, nickel_out  out  1 each  one-cycle pulse per returned coin.
- coin_reject  out  1  one-cycle pulse: a coin arrived while busy and is passed to the return chute.

## Operation
- States: IDLE (credit=0), COLLECT (0<credit<PRICE), VEND, CHANGE.
- IDLE/COLLECT:
  - coin sum = 5·nickel_p + 10·dime_p + 25·quarter_p; simultaneous pulses all count.
  - credit_next = credit + sum.
  - If cancel_p: go to CHANGE when credit_next>0, else stay IDLE. A coin arriving in the same cycle as cancel is accepted, then refunded.
  - Else if credit_next ≥ PRICE: go to VEND.
  - Else if credit_next > 0: go to COLLECT.
  - Else stay IDLE.
- VEND, one cycle:
  - dispense=1.
  - credit ← credit−PRICE.
  - Next state is CHANGE if the remainder is >0, else IDLE.
- CHANGE, one coin per cycle, greedy:
  - credit≥25: quarter_out=1, credit−=25.
  - else credit≥10: dime_out=1, credit−=10.
  - else nickel_out=1, credit−=5.
  - Go to IDLE when credit reaches 0.
- While busy, any coin pulse sets coin_reject on the next cycle and leaves credit unchanged. cancel_p is ignored while busy.
- Credit is always a multiple of 5 and never exceeds PRICE+35, so no overflow logic is needed.

## Timing
- Reset: state IDLE, credit=0; busy, dispense, all coin outputs and coin_reject =0.
- Reset mid-VEND or mid-CHANGE aborts immediately. Remaining credit is lost and no further pulses are issued.
- Coin pulse in cycle n: credit reflects it in cycle n+1.
- If that coin brings credit to PRICE or more, VEND/dispense occurs in cycle n+1.
- First change coin appears in cycle n+2; a change of c cents completes within ⌈c/25⌉+2 cycles.
- Outputs decode from registered state and credit only; there is no combinational path from inputs to outputs.
- coin_reject is registered and asserts exactly one cycle after the offending pulse.
- At most one of quarter_out/dime_out/nickel_out is high in any cycle; dispense is never high together with any of them.
- Back-to-back coin pulses every cycle are legal.

## Structure
- vend_pkg holds:
  - the state enum (IDLE, COLLECT, VEND, CHANGE);
  - coin value constants (NICKEL=5, DIME=10, QUARTER=25);
  - a compile-time check that PRICE is a multiple of 5 and ≤215.
- One combinational sub-module, vend_change_sel: input is credit; outputs are a one-hot coin select and the decrement value.
- The FSM and credit register stay in vend_fsm.

## Test plan
- Assert reset for 2 cycles → credit=0, busy=0, all pulse outputs 0, state IDLE.
- quarter, quarter, dime, nickel on consecutive cycles (PRICE=65) → credit 25, 50, 60, then VEND with dispense for 1 cycle, credit=0, no change pulses, back to IDLE.
- Three quarters → dispense, then a single dime_out pulse, credit 0, IDLE.
- quarter_p and dime_p in the same cycle → credit=35 next cycle, state COLLECT.
- quarter then cancel_p → one quarter_out pulse, no dispense, credit 0. Separately, a dime_p pulse during CHANGE → coin_reject one cycle later, change sequence unaffected.
- Two quarters plus dime plus quarter (85¢) with reset asserted on the first CHANGE cycle → no further coin outputs, credit=0 the following cycle.
